// File: rtl/mem_responder_if.sv
// Memory request/response bus between a requester and the mem_responder target.
// The master drives requests. The slave returns a ready pulse and read data.
interface mem_responder_if;
  logic        memory_valid;
  logic        memory_instr;
  logic [31:0] memory_addr;
  logic [31:0] memory_wdata;
  logic [3:0]  memory_wstrb;
  logic [31:0] memory_rdata;
  logic        memory_ready;

  modport master (
    output memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
    input  memory_rdata, memory_ready
  );

  modport slave (
    input  memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
    output memory_rdata, memory_ready
  );
endinterface

// File: rtl/mem_responder.sv
// Single-clock memory target. It accepts one request at a time and waits a fixed latency.
// It then raises ready for one cycle:
//  - Reads return the addressed word during that cycle.
//  - Byte-strobed writes commit on the edge that leaves the response cycle.
module mem_responder #(
  parameter int words   = 1024,
  parameter int latency = 2
) (
  input  logic           clock,
  input  logic           reset,
  mem_responder_if.slave bus
);

  localparam int IW = $clog2(words);
  localparam int CW = (latency > 2) ? $clog2(latency - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = (latency > 2) ? CW'(latency - 2) : '0;

  if (latency < 1 || words < 2 || (words & (words - 1)) != 0) begin : gen_param_err
    $error("mem_responder: latency must be >= 1 and words a power of two >= 2");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic           accept;

  logic           req_instr;
  logic [31:0]    req_addr;
  logic [31:0]    req_wdata;
  logic [3:0]     req_wstrb;

  logic [31:0]    mem [words];

  logic [IW-1:0]  idx;
  logic           is_write;
  logic           unused_req;

  assign idx        = req_addr[IW+1:2];
  assign is_write   = (req_wstrb != 4'h0);
  // The instruction tag and the alias/offset address bits are captured but never steer the access.
  assign unused_req = ^{req_instr, req_addr[31:IW+2], req_addr[1:0]};

  // Next-state logic: a new request is taken in IDLE or RESP, never while counting in WAIT.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    accept  = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (bus.memory_valid) begin
          accept  = 1'b1;
          state_d = (latency == 1) ? RESP : WAIT;
          count_d = CNT_INIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (count_q != '0) count_d = count_q - 1'b1;
        else               state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, countdown and request capture; reset drops any transaction in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      req_instr <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (accept) begin
        req_instr <= bus.memory_instr;
        req_addr  <= bus.memory_addr;
        req_wdata <= bus.memory_wdata;
        req_wstrb <= bus.memory_wstrb;
      end
    end
  end

  // Byte-lane write commit on the edge that ends the response cycle.
  // Contents are not cleared by reset.
  always_ff @(posedge clock) begin
    if (state_q == RESP && is_write) begin
      for (int i = 0; i < 4; i++) begin
        if (req_wstrb[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  // Response is decoded from state registers only.
  // Reading the array directly lets a back-to-back read see the write committed on the same edge.
  assign bus.memory_ready = (state_q == RESP);
  assign bus.memory_rdata = (state_q == RESP && !is_write) ? mem[idx] : 32'h0;

endmodule
